// File: rtl/ag32gbd_buffer_writer.sv
// Byte-stream to BRAM buffer-write client: one request/done handshake per byte, FlipBuffer toggles per full buffer.
// Request rises one cycle after acceptance; in_ready is low until done (plus one flip cycle), so stream stalls for slow controllers.
module ag32gbd_buffer_writer #(
  parameter int BUFFER_BYTES = 256
) (
  input  logic       sys_clock,
  input  logic       resetn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       frame_sync,
  output logic       RequestWriteBuffer,
  output logic [7:0] BufferWriteData,
  output logic [9:0] BufferWriteOffset,
  input  logic       BufferWriteDataDone,
  output logic       FlipBuffer,
  output logic       buffer_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FLIP = 2'd2
  } state_t;

  localparam logic [7:0] LAST_OFFSET = 8'(BUFFER_BYTES - 1);

  state_t     state;
  state_t     nextState;
  logic [7:0] offset;
  logic       syncPending;
  logic       lastByte;

  // Flip decision follows the offset the byte was actually written at, not the counter.
  assign lastByte = (BufferWriteOffset[7:0] == LAST_OFFSET);

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE: if (in_valid) nextState = S_REQ;
      S_REQ: begin
        if (BufferWriteDataDone) begin
          nextState = lastByte ? S_FLIP : S_IDLE;
        end
      end
      S_FLIP:  nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE);
  end

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      RequestWriteBuffer <= 1'b0;
      BufferWriteData    <= 8'd0;
      BufferWriteOffset  <= 10'd0;
      FlipBuffer         <= 1'b0;
      buffer_done        <= 1'b0;
      offset             <= 8'd0;
      syncPending        <= 1'b0;
    end else begin
      buffer_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_sync) offset <= 8'd0;
          if (in_valid) begin
            RequestWriteBuffer <= 1'b1;
            BufferWriteData    <= in_data;
            // A coincident sync re-addresses this byte to the start of the buffer.
            BufferWriteOffset  <= {2'b00, (frame_sync ? 8'd0 : offset)};
          end
        end
        S_REQ: begin
          if (frame_sync) syncPending <= 1'b1;
          if (BufferWriteDataDone) begin
            RequestWriteBuffer <= 1'b0;
            if (syncPending || frame_sync) begin
              offset      <= 8'd0;
              syncPending <= 1'b0;
            end else if (offset == LAST_OFFSET) begin
              offset <= 8'd0;
            end else begin
              offset <= offset + 8'd1;
            end
          end
        end
        S_FLIP: begin
          FlipBuffer  <= ~FlipBuffer;
          buffer_done <= 1'b1;
          if (frame_sync) offset <= 8'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ag32gbd_buffer_writer.sv
// Bench for ag32gbd_buffer_writer: a 256-byte and a 4-byte instance, selected by sel, checked against an offset/flip model.
module tb_ag32gbd_buffer_writer;

  logic       sys_clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic       done = 1'b0;
  logic       sel = 1'b0;

  logic       ready0, req0, flip0, bdone0;
  logic [7:0] data0;
  logic [9:0] off0;
  logic       ready1, req1, flip1, bdone1;
  logic [7:0] data1;
  logic [9:0] off1;

  logic       valid0, valid1, sync0, sync1, done0, done1;
  assign valid0 = in_valid & ~sel;
  assign valid1 = in_valid & sel;
  assign sync0  = frame_sync & ~sel;
  assign sync1  = frame_sync & sel;
  assign done0  = done & ~sel;
  assign done1  = done & sel;

  logic       obsReady, obsReq, obsFlip, obsBdone;
  logic [7:0] obsData;
  logic [9:0] obsOff;
  assign obsReady = sel ? ready1 : ready0;
  assign obsReq   = sel ? req1   : req0;
  assign obsFlip  = sel ? flip1  : flip0;
  assign obsBdone = sel ? bdone1 : bdone0;
  assign obsData  = sel ? data1  : data0;
  assign obsOff   = sel ? off1   : off0;

  ag32gbd_buffer_writer #(.BUFFER_BYTES(256)) dutBig (
    .sys_clock(sys_clock), .resetn(resetn), .in_data(in_data), .in_valid(valid0),
    .in_ready(ready0), .frame_sync(sync0), .RequestWriteBuffer(req0),
    .BufferWriteData(data0), .BufferWriteOffset(off0), .BufferWriteDataDone(done0),
    .FlipBuffer(flip0), .buffer_done(bdone0)
  );

  ag32gbd_buffer_writer #(.BUFFER_BYTES(4)) dutSmall (
    .sys_clock(sys_clock), .resetn(resetn), .in_data(in_data), .in_valid(valid1),
    .in_ready(ready1), .frame_sync(sync1), .RequestWriteBuffer(req1),
    .BufferWriteData(data1), .BufferWriteOffset(off1), .BufferWriteDataDone(done1),
    .FlipBuffer(flip1), .buffer_done(bdone1)
  );

  always #5 sys_clock = ~sys_clock;

  int   vectors = 0;
  int   miscompares = 0;
  int   flipsSeen = 0;
  // Reference model per instance: next write offset, flip level, pending sync.
  int   expOffset [2];
  logic expFlip [2];
  bit   pending [2];

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      expOffset[k] = 0;
      expFlip[k]   = 1'b0;
      pending[k]   = 1'b0;
    end
  endtask

  // Drive one byte through the handshake, acting as the controller with doneDelay idle request cycles.
  task automatic writeByte(input logic [7:0] d, input bit syncWithValid, input int doneDelay, input int syncAt);
    int  idx;
    int  bb;
    int  wOff;
    int  budget;
    bit  last;
    idx = sel ? 1 : 0;
    bb  = sel ? 4 : 256;
    budget = 0;
    while (obsReady !== 1'b1 && budget < 20) begin
      @(negedge sys_clock);
      budget++;
    end
    vectors++;
    if (obsReady !== 1'b1) begin
      $display("FAIL ready_wait: in_ready=%b after %0d cycles, expected 1", obsReady, budget);
      miscompares++;
    end
    in_data = d;
    in_valid = 1'b1;
    frame_sync = syncWithValid;
    if (syncWithValid) expOffset[idx] = 0;
    wOff = expOffset[idx];
    @(negedge sys_clock);
    in_valid = 1'b0;
    frame_sync = 1'b0;
    vectors++;
    if (obsReq !== 1'b1 || obsData !== d || obsOff !== 10'(wOff)) begin
      $display("FAIL req_rise: req=%b data=%h off=%0d, expected req=1 data=%h off=%0d",
               obsReq, obsData, obsOff, d, wOff);
      miscompares++;
    end
    for (int i = 0; i < doneDelay; i++) begin
      if (i == syncAt) begin
        frame_sync = 1'b1;
        pending[idx] = 1'b1;
      end
      @(negedge sys_clock);
      frame_sync = 1'b0;
      vectors++;
      if (obsReq !== 1'b1 || obsData !== d || obsOff !== 10'(wOff) || obsReady !== 1'b0) begin
        $display("FAIL req_hold: cycle %0d req=%b data=%h off=%0d rdy=%b, expected req=1 data=%h off=%0d rdy=0",
                 i, obsReq, obsData, obsOff, obsReady, d, wOff);
        miscompares++;
      end
    end
    done = 1'b1;
    @(negedge sys_clock);
    done = 1'b0;
    last = (wOff == bb - 1);
    if (pending[idx]) begin
      expOffset[idx] = 0;
      pending[idx] = 1'b0;
    end else begin
      expOffset[idx] = (expOffset[idx] + 1) % bb;
    end
    vectors++;
    if (obsReq !== 1'b0 || obsReady !== !last || obsBdone !== 1'b0 || obsFlip !== expFlip[idx]) begin
      $display("FAIL req_fall: req=%b rdy=%b bdone=%b flip=%b, expected req=0 rdy=%b bdone=0 flip=%b",
               obsReq, obsReady, obsBdone, obsFlip, !last, expFlip[idx]);
      miscompares++;
    end
    if (last) begin
      expFlip[idx] = ~expFlip[idx];
      @(negedge sys_clock);
      if (obsBdone === 1'b1) flipsSeen++;
      vectors++;
      if (obsBdone !== 1'b1 || obsFlip !== expFlip[idx] || obsReady !== 1'b1) begin
        $display("FAIL flip: bdone=%b flip=%b rdy=%b, expected bdone=1 flip=%b rdy=1",
                 obsBdone, obsFlip, obsReady, expFlip[idx]);
        miscompares++;
      end
    end
  endtask

  task automatic pulseSyncIdle();
    frame_sync = 1'b1;
    @(negedge sys_clock);
    frame_sync = 1'b0;
    expOffset[sel ? 1 : 0] = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    modelReset();
    #12;
    vectors++;
    if (req0 !== 1'b0 || data0 !== 8'd0 || off0 !== 10'd0 || flip0 !== 1'b0 || bdone0 !== 1'b0 || ready0 !== 1'b1) begin
      $display("FAIL reset_big: req=%b data=%h off=%0d flip=%b bdone=%b rdy=%b, expected 0 00 0 0 0 1",
               req0, data0, off0, flip0, bdone0, ready0);
      miscompares++;
    end
    vectors++;
    if (req1 !== 1'b0 || data1 !== 8'd0 || off1 !== 10'd0 || flip1 !== 1'b0 || bdone1 !== 1'b0 || ready1 !== 1'b1) begin
      $display("FAIL reset_small: req=%b data=%h off=%0d flip=%b bdone=%b rdy=%b, expected 0 00 0 0 0 1",
               req1, data1, off1, flip1, bdone1, ready1);
      miscompares++;
    end
    @(negedge sys_clock);
    resetn = 1'b1;
    @(negedge sys_clock);
  endtask

  task automatic test_single_byte();
    writeByte(8'hA5, 1'b0, 3, -1);
  endtask

  task automatic test_full_buffer();
    int flips0;
    pulseSyncIdle();
    flips0 = flipsSeen;
    for (int i = 0; i < 256; i++) writeByte(8'(i), 1'b0, 3, -1);
    vectors++;
    if (flipsSeen - flips0 != 1 || flip0 !== 1'b1) begin
      $display("FAIL full_buffer: buffer_done pulses=%0d FlipBuffer=%b, expected 1 and 1", flipsSeen - flips0, flip0);
      miscompares++;
    end
    writeByte(8'($urandom), 1'b0, 3, -1);
  endtask

  task automatic test_contended();
    writeByte(8'($urandom), 1'b0, 20, -1);
    writeByte(8'($urandom), 1'b0, 3, -1);
  endtask

  task automatic test_sync_during_write();
    pulseSyncIdle();
    for (int i = 0; i < 37; i++) writeByte(8'($urandom), 1'b0, 3, -1);
    writeByte(8'h37, 1'b0, 10, 4);
    writeByte(8'($urandom), 1'b0, 3, -1);
    writeByte(8'($urandom), 1'b0, 3, -1);
    writeByte(8'hC3, 1'b1, 3, -1);
    writeByte(8'($urandom), 1'b0, 3, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int r;
      int dly;
      int sAt;
      r = $urandom_range(0, 9);
      if (r == 0) pulseSyncIdle();
      if (r == 1) begin
        done = 1'b1;
        @(negedge sys_clock);
        done = 1'b0;
        vectors++;
        if (obsReq !== 1'b0 || obsReady !== 1'b1) begin
          $display("FAIL stray_done: req=%b rdy=%b, expected req=0 rdy=1", obsReq, obsReady);
          miscompares++;
        end
      end
      dly = $urandom_range(0, 6);
      sAt = (dly > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, dly - 1) : -1;
      writeByte(8'($urandom), ($urandom_range(0, 7) == 0), dly, sAt);
    end
  endtask

  task automatic test_small_buffer();
    int flips0;
    sel = 1'b1;
    @(negedge sys_clock);
    flips0 = flipsSeen;
    for (int i = 0; i < 9; i++) writeByte(8'($urandom), 1'b0, 3, -1);
    vectors++;
    if (flipsSeen - flips0 != 2 || flip1 !== 1'b0) begin
      $display("FAIL small_buffer: buffer_done pulses=%0d FlipBuffer=%b, expected 2 and 0", flipsSeen - flips0, flip1);
      miscompares++;
    end
    for (int i = 0; i < 10; i++) writeByte(8'($urandom), ($urandom_range(0, 5) == 0), $urandom_range(0, 4), -1);
    sel = 1'b0;
    @(negedge sys_clock);
  endtask

  task automatic test_reset_mid_request();
    in_data = 8'h5A;
    in_valid = 1'b1;
    @(negedge sys_clock);
    in_valid = 1'b0;
    repeat (2) @(negedge sys_clock);
    vectors++;
    if (req0 !== 1'b1) begin
      $display("FAIL pre_reset_req: req=%b, expected 1", req0);
      miscompares++;
    end
    #2;
    resetn = 1'b0;
    modelReset();
    #1;
    vectors++;
    if (req0 !== 1'b0 || data0 !== 8'd0 || off0 !== 10'd0 || flip0 !== 1'b0 || bdone0 !== 1'b0 || ready0 !== 1'b1) begin
      $display("FAIL reset_mid: req=%b data=%h off=%0d flip=%b bdone=%b rdy=%b, expected 0 00 0 0 0 1",
               req0, data0, off0, flip0, bdone0, ready0);
      miscompares++;
    end
    @(negedge sys_clock);
    resetn = 1'b1;
    @(negedge sys_clock);
    writeByte(8'h3C, 1'b0, 3, -1);
    writeByte(8'h3D, 1'b0, 3, -1);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_full_buffer();
    test_contended();
    test_sync_during_write();
    test_random();
    test_small_buffer();
    test_reset_mid_request();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
